fir_top: RTL and testbench
==========================

Name: fir_top

Overview:
Self-contained waveform generator plus 8-tap low-pass FIR for demo and bring-up.
- A free-running 8-bit phase counter addresses four built-in 256-entry waveform tables.
- rom_sel chooses which table drives douta.
- The selected sample stream is filtered by a fixed-coefficient FIR, and the result appears on fir_out_data.
- Sits at the top of the FIR demo design; no handshakes, one sample per clock.

Parameters:
DATA_W, 8, sample and output width (offset-binary unsigned).
NTAPS, 8, number of FIR taps (fixed by the coefficient set).
COEF, {2,8,18,36,36,18,8,2}, signed 8-bit tap coefficients c0..c7; sum 128 gives unity DC gain.
SHIFT, 7, right shift applied to the accumulator (log2 of coefficient sum).

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-high reset. Asserted at 1 despite the name, as already decided; any logic 1 clears all state immediately.
rom_sel  input  2  waveform select: 0 = sine, 1 = square, 2 = triangle, 3 = sawtooth.
douta  output  8  registered selected waveform sample, offset binary (0x80 = zero).
fir_out_data  output  8  registered FIR output, offset binary.

Behaviour:
- Reset (async, rst_n=1) sets:
  - phase counter addr = 0
  - douta = 0x80
  - delay line x0..x7 = 0 (signed)
  - fir_out_data = 0x80
- Each clock with rst_n=0:
  - addr <= addr+1, wrapping 255 -> 0.
  - douta <= table[rom_sel][addr].
- Tables (index i = addr):
  - sine: round(128 + 127*sin(2*pi*i/256)).
  - square: 0xFF for i<128, 0x01 for i>=128.
  - triangle: i<128 ? 2*i : 255-2*(i-128).
  - sawtooth: i.
- FIR, each clock:
  - x0 <= signed(douta ^ 0x80); xk <= x(k-1) for k=1..7.
  - acc = sum ck*xk, signed 17 bits; products are 8x8 signed.
  - fir_out_data <= (acc >>> 7) ^ 0x80, arithmetic shift (floor), low 8 bits.
  - No saturation is needed: all coefficients are positive with sum 128, so |result| <= 128 and it fits.
- Latency:
  - douta reflects addr sampled at the previous edge.
  - A douta value enters x0 one clock later.
  - Its first effect on fir_out_data appears one clock after that, i.e. 2 clocks from douta.
  - A constant douta reaches steady state on fir_out_data after 9 clocks.
- rom_sel change: takes effect on the next douta update. Phase counter and delay line are not reset; the output transitions smoothly through the filter.
- rom_sel is sampled synchronously; no glitch filtering is applied.
- Reset mid-run: all outputs return to 0x80 at once. After release, sequencing restarts from addr=0 with the first douta = table[sel][0].

Decomposition:
- Package fir_pkg holds:
  - DATA_W, NTAPS, SHIFT
  - COEF array
  - rom_sel encodings (SEL_SINE=0, SEL_SQUARE=1, SEL_TRI=2, SEL_SAW=3)
  - 256-entry sine table constant
- One sub-module, wave_rom: combinational (sel, addr) -> sample.
- fir_top holds the counter, the douta register, the delay line, the MAC and the output register.

Test Plan:
- Reset: hold rst_n=1 for 10 clocks -> douta=0x80, fir_out_data=0x80. Assert rst_n asynchronously mid-cycle -> outputs 0x80 before the next edge.
- Sawtooth (sel=3) after reset -> douta sequence 0x00,0x01,0x02,... one per clock, wraps 0xFF->0x00 after 256 clocks.
- Square (sel=1): once 8+ consecutive 0xFF samples are in the line -> fir_out_data=0xFF. Once 8+ consecutive 0x01 samples are in the line -> fir_out_data=0x01.
- Impulse response: drive the delay line from reset (all zeros) with one +127 sample followed by zeros. Observed sequence (>>>7, floor) is 0x81,0x87,0x91,0xA3,0xA3,0x91,0x87,0x81, then 0x80.
- Sine (sel=0) for 256 clocks -> douta matches the table. fir_out_data is a smooth sinusoid, lagging douta by about 5.5 samples.
- rom_sel switch 0->1->2 at arbitrary clocks -> addr continues without restart. douta switches on the next edge. fir_out_data shows no out-of-range values.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the waveform/FIR demo: widths, taps, select codes and the sine table.
package fir_pkg;

  localparam int DATA_W = 8;
  localparam int NTAPS  = 8;
  localparam int SHIFT  = 7;
  localparam int ACC_W  = 17;

  typedef enum logic [1:0] {
    SEL_SINE   = 2'd0,
    SEL_SQUARE = 2'd1,
    SEL_TRI    = 2'd2,
    SEL_SAW    = 2'd3
  } sel_e;

  localparam logic signed [7:0] COEF [NTAPS] = '{
    8'sd2, 8'sd8, 8'sd18, 8'sd36, 8'sd36, 8'sd18, 8'sd8, 8'sd2
  };

  // Quarter wave, round(128 + 127*sin(2*pi*i/256)) for i = 0..64.
  localparam int SINE_Q [65] = '{
    128, 131, 134, 137, 140, 144, 147, 150, 153, 156,
    159, 162, 165, 168, 171, 174, 177, 179, 182, 185,
    188, 191, 193, 196, 199, 201, 204, 206, 209, 211,
    213, 216, 218, 220, 222, 224, 226, 228, 230, 232,
    234, 235, 237, 239, 240, 241, 243, 244, 245, 246,
    248, 249, 250, 250, 251, 252, 253, 253, 254, 254,
    254, 255, 255, 255, 255
  };

  typedef logic [255:0][DATA_W-1:0] sine_tab_t;

  // Unfold the quarter wave: mirror for the second quarter, reflect about 128 for the lower half.
  function automatic sine_tab_t build_sine();
    sine_tab_t t;
    int j;
    int q;
    int v;
    for (int i = 0; i < 256; i++) begin
      j = i % 128;
      q = (j <= 64) ? j : 128 - j;
      v = (i < 128) ? SINE_Q[q] : 256 - SINE_Q[q];
      t[i] = DATA_W'(v);
    end
    return t;
  endfunction

  localparam sine_tab_t SINE_TAB = build_sine();

endpackage

// File: rtl/fir_wave_rom.sv
// Combinational waveform lookup: four 256-entry tables selected by sel_i.
module wave_rom
  import fir_pkg::*;
(
  input  logic [1:0]        sel_i,
  input  logic [7:0]        addr_i,
  output logic [DATA_W-1:0] sample_o
);

  always_comb begin
    sample_o = addr_i;
    case (sel_i)
      SEL_SINE:   sample_o = SINE_TAB[addr_i];
      SEL_SQUARE: sample_o = addr_i[7] ? 8'h01 : 8'hFF;
      // Falling half is 255-2*(i-128), i.e. the bitwise inverse of the rising ramp.
      SEL_TRI:    sample_o = addr_i[7] ? ~{addr_i[6:0], 1'b0} : {addr_i[6:0], 1'b0};
      SEL_SAW:    sample_o = addr_i;
      default:    sample_o = addr_i;
    endcase
  end

endmodule

// File: rtl/fir_top.sv
// Free-running waveform generator feeding a fixed 8-tap low-pass FIR, one sample per clock.
module fir_top
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rom_sel,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] fir_out_data
);

  logic [7:0]               addr_q, addr_d;
  logic [DATA_W-1:0]        douta_q, douta_d;
  logic [DATA_W-1:0]        fir_q, fir_d;
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [15:0]       prod;

  wave_rom u_rom (
    .sel_i    (rom_sel),
    .addr_i   (addr_q),
    .sample_o (douta_d)
  );

  assign addr_d = addr_q + 8'd1;

  always_comb begin
    acc_d = '0;
    prod  = '0;
    for (int k = 0; k < NTAPS; k++) begin
      prod  = COEF[k] * x_q[k];
      acc_d = acc_d + ACC_W'(prod);
    end
  end

  // Arithmetic shift floors toward -inf; coefficient sum of 128 keeps the result within 8 bits.
  assign fir_d = DATA_W'(acc_d >>> SHIFT) ^ 8'h80;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      addr_q  <= '0;
      douta_q <= 8'h80;
      fir_q   <= 8'h80;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
    end else begin
      addr_q  <= addr_d;
      douta_q <= douta_d;
      fir_q   <= fir_d;
      x_q[0]  <= $signed(douta_q ^ 8'h80);
      for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  assign douta        = douta_q;
  assign fir_out_data = fir_q;

endmodule

// File: tb/tb_fir_top.sv
// Directed bench with a reference model feeding a scoreboard of expected douta/fir_out_data pairs.
module tb_fir_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rom_sel;
  logic [7:0] douta;
  logic [7:0] fir_out_data;

  int tests = 0;
  int fails = 0;

  int addr_m;
  int dout_m;
  int x_m [8];
  int coef_m [8] = '{2, 8, 18, 36, 36, 18, 8, 2};
  logic [15:0] sb_q [$];

  fir_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_sel      (rom_sel),
    .douta        (douta),
    .fir_out_data (fir_out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tab(input logic [1:0] s, input int i);
    real r;
    case (s)
      2'd0: begin
        r = 128.0 + 127.0 * $sin(2.0 * 3.141592653589793 * i / 256.0);
        return 8'($rtoi($floor(r + 0.5)));
      end
      2'd1: return (i < 128) ? 8'hFF : 8'h01;
      2'd2: return (i < 128) ? 8'(2 * i) : 8'(255 - 2 * (i - 128));
      default: return 8'(i);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    addr_m = 0;
    dout_m = 128;
    for (int k = 0; k < 8; k++) x_m[k] = 0;
    sb_q.delete();
  endtask

  // Predict the state after the coming edge, push it, then compare once the DUT has clocked.
  task automatic step(input logic [1:0] s, input string tag);
    int acc;
    int f;
    logic [7:0] fexp;
    logic [7:0] dexp;
    logic [15:0] e;
    rom_sel = s;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += coef_m[k] * x_m[k];
    f = $rtoi($floor(real'(acc) / 128.0));
    fexp = 8'(f) ^ 8'h80;
    for (int k = 7; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = dout_m - 128;
    dexp = tab(s, addr_m);
    dout_m = int'(dexp);
    addr_m = (addr_m + 1) % 256;
    sb_q.push_back({dexp, fexp});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, "_douta"}, douta, e[15:8]);
    chk({tag, "_fir"}, fir_out_data, e[7:0]);
  endtask

  initial begin
    rst_n   = 1'b1;
    rom_sel = 2'd0;
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("reset_douta", douta, 8'h80);
    chk("reset_fir", fir_out_data, 8'h80);

    // Sawtooth across the 255 -> 0 wrap
    @(negedge clk);
    rst_n = 1'b0;
    for (int n = 0; n < 260; n++) step(2'd3, "saw");

    // Asynchronous reset asserted away from any edge
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_rst_douta", douta, 8'h80);
    chk("async_rst_fir", fir_out_data, 8'h80);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    // Square: steady high then steady low through the full filter
    for (int n = 1; n <= 256; n++) begin
      step(2'd1, "square");
      if (n == 100) chk("square_high_steady", fir_out_data, 8'hFF);
      if (n == 200) chk("square_low_steady", fir_out_data, 8'h01);
    end

    // Sine for a full period from a fresh reset
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int n = 0; n < 256; n++) step(2'd0, "sine");

    // Live select changes without restarting the phase counter
    for (int n = 0; n < 37; n++) step(2'd0, "sw_sine");
    for (int n = 0; n < 53; n++) step(2'd1, "sw_square");
    for (int n = 0; n < 90; n++) step(2'd2, "sw_tri");
    for (int n = 0; n < 20; n++) step(2'd3, "sw_saw");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
